// File: rtl/ff_learn_pkg.sv
// Shared constants, FSM states and saturating add for the forward-forward learning update engines.
// Latency: n/a (types and combinational helper only).
// Backpressure: n/a.
package ff_learn_pkg;

  localparam int W_W     = 8;   // signed synaptic weight width
  localparam int ROM_AW  = 8;   // derivative ROM address width: {post_q, pre_q}
  localparam int ROM_DW  = 9;   // derivative ROM signed data width
  localparam int TRACE_W = 4;   // quantized trace nibble width

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_e;

  // weight + delta evaluated at W_W+2 bits, clamped to the signed weight range.
  // The sum overflows the weight range exactly when the top three bits disagree.
  function automatic logic [W_W-1:0] sat_add(input logic [W_W-1:0]    w,
                                             input logic [ROM_DW-1:0] d);
    logic [W_W+1:0] s;
    s = {{2{w[W_W-1]}}, w} + {{(W_W+2-ROM_DW){d[ROM_DW-1]}}, d};
    if ((&s[W_W+1:W_W-1]) || (~|s[W_W+1:W_W-1])) begin
      return s[W_W-1:0];
    end else if (s[W_W+1]) begin
      return {1'b1, {(W_W-1){1'b0}}};
    end else begin
      return {1'b0, {(W_W-1){1'b1}}};
    end
  endfunction

endpackage

// File: rtl/upd_fifo2.sv
// Two-entry synchronous FIFO holding pending weight write-backs.
// Latency: push visible at head_o the cycle after the push.
// Backpressure: none internally; the producer's credit rule keeps it from overflowing.
// Ports: clk/rst_n; push_i + push_dat_i; pop_i; count_o occupancy; head_o oldest entry.
module upd_fifo2 #(
  parameter int DW = 20
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic [DW-1:0] push_dat_i,
  input  logic          pop_i,
  output logic [1:0]    count_o,
  output logic [DW-1:0] head_o
);

  logic [DW-1:0] mem_q [2];
  logic          wptr_q;
  logic          rptr_q;
  logic [1:0]    count_q;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop_i & (count_q != 2'd0);
  // A push into a full FIFO is still legal when the head leaves in the same cycle.
  assign do_push = push_i & ((count_q != 2'd2) | do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wptr_q   <= 1'b0;
      rptr_q   <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= push_dat_i;
        wptr_q        <= ~wptr_q;
      end
      if (do_pop) begin
        rptr_q <= ~rptr_q;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rptr_q];

endmodule

// File: rtl/neg_weight_update_engine.sv
// Negative-phase weight update: ROM derivative lookup, shift-scaled saturating add, write-back stream, batch FSM.
// Latency: accept at T -> out_valid at T+2 (ROM register at T+1, FIFO head at T+2).
// Backpressure: in_ready only while FIFO occupancy plus the in-flight ROM slot is below 2, since the ROM cannot stall.
// Ports: start/n_syn/lr_shift batch control; in_* request stream; rom_addr/rom_dout ROM link;
//        out_* write-back stream; busy while not IDLE; done one-cycle pulse at batch end.
module neg_weight_update_engine
  import ff_learn_pkg::*;
#(
  parameter int WADDR_W = 12,
  parameter int CNT_W   = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [CNT_W-1:0]   n_syn,
  input  logic [2:0]         lr_shift,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [TRACE_W-1:0] in_pre_q,
  input  logic [TRACE_W-1:0] in_post_q,
  input  logic [W_W-1:0]     in_weight,
  input  logic [WADDR_W-1:0] in_waddr,
  output logic [ROM_AW-1:0]  rom_addr,
  input  logic [ROM_DW-1:0]  rom_dout,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [W_W-1:0]     out_weight,
  output logic [WADDR_W-1:0] out_waddr,
  output logic               busy,
  output logic               done
);

  state_e                    state_q;
  logic [CNT_W-1:0]          n_syn_q;
  logic [CNT_W-1:0]          cnt_q;
  logic [2:0]                lr_shift_q;
  logic                      busy_q;
  logic                      done_q;

  logic                      inflight_q;
  logic [W_W-1:0]            b_weight_q;
  logic [WADDR_W-1:0]        b_waddr_q;
  logic [ROM_AW-1:0]         rom_addr_q;

  logic [1:0]                fifo_count;
  logic [W_W+WADDR_W-1:0]    fifo_head;
  logic [W_W+WADDR_W-1:0]    push_dat;
  logic                      credit_ok;
  logic                      accept;
  logic                      pop;
  logic signed [ROM_DW-1:0]  delta;

  // Credit covers both FIFO entries and the request whose ROM word is in flight.
  // With out_ready held high this sustains two accepts every three cycles.
  assign credit_ok = (fifo_count == 2'd0) || ((fifo_count == 2'd1) && !inflight_q);
  assign in_ready  = (state_q == RUN) && credit_ok;
  assign accept    = in_valid && in_ready;

  // Address is live in the accept cycle; otherwise the last one is held.
  assign rom_addr  = accept ? {in_post_q, in_pre_q} : rom_addr_q;

  // Arithmetic shift keeps the sign, so small negative derivatives floor to -1, not 0.
  assign delta     = $signed(rom_dout) >>> lr_shift_q;
  assign push_dat  = {sat_add(b_weight_q, delta), b_waddr_q};

  // Stage B: weight/address wait here for the registered ROM word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q <= 1'b0;
      b_weight_q <= '0;
      b_waddr_q  <= '0;
      rom_addr_q <= '0;
    end else begin
      inflight_q <= accept;
      if (accept) begin
        b_weight_q <= in_weight;
        b_waddr_q  <= in_waddr;
        rom_addr_q <= {in_post_q, in_pre_q};
      end
    end
  end

  upd_fifo2 #(
    .DW (W_W + WADDR_W)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (inflight_q),
    .push_dat_i (push_dat),
    .pop_i      (pop),
    .count_o    (fifo_count),
    .head_o     (fifo_head)
  );

  assign out_valid               = (fifo_count != 2'd0);
  assign pop                     = out_valid && out_ready;
  assign {out_weight, out_waddr} = fifo_head;

  // Batch FSM; busy/done are registered alongside the state they decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      n_syn_q    <= '0;
      cnt_q      <= '0;
      lr_shift_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            n_syn_q    <= n_syn;
            lr_shift_q <= lr_shift;
            cnt_q      <= '0;
            busy_q     <= 1'b1;
            if (n_syn == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          if (accept) begin
            cnt_q <= cnt_q + CNT_W'(1);
            if ((cnt_q + CNT_W'(1)) == n_syn_q) begin
              state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (!inflight_q && (fifo_count == 2'd0)) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_neg_weight_update_engine.sv
// Self-checking bench for neg_weight_update_engine: directed update cases, credit stall, random batches, mid-batch reset.
// Latency: n/a.
// Backpressure: out_ready driven from a schedule or at random.
module tb_neg_weight_update_engine;
  import ff_learn_pkg::*;

  localparam int WADDR_W = 12;
  localparam int CNT_W   = 12;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic [CNT_W-1:0]   n_syn = '0;
  logic [2:0]         lr_shift = '0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [3:0]         in_pre_q = '0;
  logic [3:0]         in_post_q = '0;
  logic [7:0]         in_weight = '0;
  logic [WADDR_W-1:0] in_waddr = '0;
  logic [7:0]         rom_addr;
  logic [8:0]         rom_dout = '0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [7:0]         out_weight;
  logic [WADDR_W-1:0] out_waddr;
  logic               busy;
  logic               done;

  neg_weight_update_engine #(.WADDR_W(WADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .n_syn(n_syn), .lr_shift(lr_shift),
    .in_valid(in_valid), .in_ready(in_ready), .in_pre_q(in_pre_q), .in_post_q(in_post_q),
    .in_weight(in_weight), .in_waddr(in_waddr), .rom_addr(rom_addr), .rom_dout(rom_dout),
    .out_valid(out_valid), .out_ready(out_ready), .out_weight(out_weight), .out_waddr(out_waddr),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Derivative ROM stand-in with one registered cycle of read latency.
  logic [8:0] rom_tbl [256];
  always @(posedge clk) rom_dout <= rom_tbl[rom_addr];

  int total = 0;
  int bad   = 0;

  typedef struct { int w; int a; } exp_t;
  exp_t q[$];
  int   cur_sh;
  bit   acc_s, rdy_s;
  int   ndone, nout, nacc;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int rom_val(input logic [7:0] a);
    logic signed [8:0] v;
    v = rom_tbl[a];
    return int'(v);
  endfunction

  // Reference: weight + floor(derivative / 2^shift), clamped to the signed 8-bit range.
  function automatic int model(input int w, input int r, input int sh);
    int dv, d, s;
    dv = 1 << sh;
    d  = r / dv;
    if (r < 0 && (r % dv) != 0) d = d - 1;
    s = w + d;
    if (s > 127)  s = 127;
    if (s < -128) s = -128;
    return s;
  endfunction

  task automatic new_req();
    in_pre_q  = 4'($urandom_range(0, 15));
    in_post_q = 4'($urandom_range(0, 15));
    in_weight = 8'($urandom_range(0, 255));
    in_waddr  = WADDR_W'($urandom_range(0, 4095));
  endtask

  // One clock: sample at the falling edge, score outputs/accepts, return just after the rising edge.
  task automatic step();
    @(negedge clk);
    rdy_s = in_ready;
    acc_s = in_valid && in_ready;
    if (out_valid && out_ready) begin
      nout++;
      check("sb_nonempty", int'(q.size() > 0), 1);
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        check("wb_weight", int'($signed(out_weight)), e.w);
        check("wb_waddr", int'(out_waddr), e.a);
      end
    end
    if (acc_s) begin
      nacc++;
      check("rom_addr_accept", int'(rom_addr), int'({in_post_q, in_pre_q}));
      q.push_back('{model(int'($signed(in_weight)), rom_val({in_post_q, in_pre_q}), cur_sh),
                    int'(in_waddr)});
    end
    if (done) ndone++;
    @(posedge clk);
    #1;
  endtask

  task automatic single(input logic [3:0] pre, input logic [3:0] post, input logic [2:0] sh,
                        input int w, input int exp_w, input string tag);
    int waited;
    logic [WADDR_W-1:0] a;
    a = WADDR_W'($urandom_range(0, 4095));
    out_ready = 1'b1;
    start = 1'b1; n_syn = CNT_W'(1); lr_shift = sh;
    @(posedge clk); #1;
    start = 1'b0;
    in_valid = 1'b1; in_pre_q = pre; in_post_q = post; in_weight = w[7:0]; in_waddr = a;
    @(negedge clk);
    check({tag, "_in_ready"}, int'(in_ready), 1);
    check({tag, "_rom_addr"}, int'(rom_addr), int'({post, pre}));
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check({tag, "_no_early_out"}, int'(out_valid), 0);
    @(posedge clk); #1;
    @(negedge clk);
    check({tag, "_out_valid_t2"}, int'(out_valid), 1);
    check({tag, "_out_weight"}, int'($signed(out_weight)), exp_w);
    check({tag, "_out_waddr"}, int'(out_waddr), int'(a));
    waited = 0;
    while (!done && waited < 8) begin
      @(posedge clk); #1;
      @(negedge clk);
      waited++;
    end
    check({tag, "_done"}, int'(done), 1);
    @(posedge clk); #1;
    @(negedge clk);
    check({tag, "_done_pulse_end"}, int'(done), 0);
    check({tag, "_busy_fall"}, int'(busy), 0);
    @(posedge clk); #1;
  endtask

  task automatic run_rand(input int n, input logic [2:0] sh, input int low, input bit rnd,
                          input string tag);
    int cyc, sent;
    ndone = 0; nout = 0; nacc = 0;
    q.delete();
    cur_sh = int'(sh);
    out_ready = 1'b0;
    start = 1'b1; n_syn = n[CNT_W-1:0]; lr_shift = sh;
    @(posedge clk); #1;
    start = 1'b0;
    sent = 0; cyc = 0;
    new_req();
    while (ndone == 0 && cyc < 300) begin
      in_valid  = (sent < n);
      out_ready = (cyc < low) ? 1'b0 : (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
      step();
      if (acc_s) begin
        sent++;
        new_req();
      end
      if (cyc == 2 && low >= 3) begin
        check({tag, "_credit_stall"}, int'(rdy_s), 0);
        check({tag, "_two_accepts"}, nacc, 2);
      end
      cyc++;
    end
    if (n == 0) check({tag, "_fast_done"}, int'(cyc <= 2), 1);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) step();
    check({tag, "_done_count"}, ndone, 1);
    check({tag, "_accepts"}, nacc, n);
    check({tag, "_outputs"}, nout, n);
    check({tag, "_sb_empty"}, q.size(), 0);
    check({tag, "_idle_busy"}, int'(busy), 0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom_tbl[i] = 9'($urandom_range(0, 511));
    rom_tbl[8'hFF] = 9'h1F0;   // -16
    rom_tbl[8'h08] = 9'h1FF;   // -1
    rom_tbl[8'h00] = 9'h000;
    rom_tbl[8'h11] = 9'd200;

    // Reset state
    #3;
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_rom_addr", int'(rom_addr), 0);
    check("rst_out_weight", int'(out_weight), 0);
    check("rst_out_waddr", int'(out_waddr), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed single-synapse batches
    single(4'hF, 4'hF, 3'd0,   10,   -6, "basic");
    single(4'hF, 4'hF, 3'd0, -120, -128, "sat_neg");
    single(4'hF, 4'hF, 3'd2,    0,   -4, "shift2");
    single(4'h8, 4'h0, 3'd3,    5,    4, "ashr_neg1");
    single(4'h0, 4'h0, 3'd0,    7,    7, "zero_deriv");
    single(4'h1, 4'h1, 3'd0,  100,  127, "sat_pos");

    // Burst against a stalled sink, empty batch, random batch with random backpressure
    run_rand(8, 3'd0, 5, 1'b0, "burst8");
    run_rand(0, 3'd0, 0, 1'b0, "nsyn0");
    run_rand(12, 3'($urandom_range(0, 7)), 2, 1'b1, "rand12");

    // Mid-batch reset with the FIFO full
    q.delete();
    cur_sh = 1;
    out_ready = 1'b0;
    start = 1'b1; n_syn = CNT_W'(8); lr_shift = 3'd1;
    @(posedge clk); #1;
    start = 1'b0;
    in_valid = 1'b1;
    new_req();
    repeat (4) begin
      step();
      if (acc_s) new_req();
    end
    @(negedge clk);
    check("prerst_out_valid", int'(out_valid), 1);
    check("prerst_in_ready", int'(in_ready), 0);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_in_ready", int'(in_ready), 0);
    check("midrst_done", int'(done), 0);
    in_valid = 1'b0;
    q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    ndone = 0; nout = 0; nacc = 0;
    repeat (3) step();
    check("postrst_no_done", ndone, 0);
    check("postrst_no_out", nout, 0);
    run_rand(5, 3'd1, 1, 1'b1, "after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
